mem_arbiter_rr: RTL and testbench
=================================

# mem_arbiter_rr

Parametrised N-port memory arbiter that supersedes the fixed two-peripheral arbiter between the LED matrix controller, device controller and the external memory port. Each peripheral gets its own request FIFO. A round-robin grant stage issues one command per accepted handshake to a valid/ready memory command port. Read returns are routed back to the issuing peripheral through an in-order tag FIFO, so multiple reads can be outstanding.

## Interface
Parameters:
- ADDRESS_WIDTH, 25, memory address width
- DATA_WIDTH, 8, data width
- PERIPHERALS, 2, number of requesting ports (2..8)
- REQ_FIFO_DEPTH, 4, per-peripheral request FIFO depth (power of 2, ≥2)
- MAX_OUTSTANDING, 4, maximum reads in flight (power of 2, ≥1)

Ports:
- clk  in  1  system clock, the single clock domain
- reset_n  in  1  asynchronous active-low reset
- address  in  PERIPHERALS*ADDRESS_WIDTH  packed request addresses; peripheral i is in slice i
- wr  in  PERIPHERALS  request is a write when 1, a read when 0
- data_in  in  PERIPHERALS*DATA_WIDTH  write data
- data_in_ready  in  PERIPHERALS  one-cycle push strobe per peripheral
- fifo_full  out  PERIPHERALS  request FIFO i is full
- overflow  out  PERIPHERALS  sticky: a push was dropped
- data_out  out  DATA_WIDTH  read data, shared by all peripherals
- data_out_ready  out  PERIPHERALS  one-hot read-data valid
- mem_cmd_valid  out  1  command valid
- mem_cmd_ready  in  1  memory accepts the command
- mem_cmd_wr  out  1  command type
- mem_cmd_address  out  ADDRESS_WIDTH  command address
- mem_cmd_data  out  DATA_WIDTH  write data
- mem_rd_valid  in  1  read data return, in issue order
- mem_rd_data  in  DATA_WIDTH  returned read data

## Operation
- Push:
  - data_in_ready[i] with fifo_full[i]=0 enqueues {wr[i], address slice i, data_in slice i}.
  - A push while fifo_full[i]=1 is dropped and sets overflow[i]. This holds even if a pop happens in the same cycle.
  - Simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- Eligibility:
  - Peripheral i is eligible when its FIFO is non-empty.
  - For a read, the tag FIFO must also be not full. A read head with the tag FIFO full is skipped and other peripherals' writes still proceed.
- Command stage: two states.
  - IDLE: if any peripheral is eligible, grant one, pop its head into the command register, assert mem_cmd_valid, go to BUSY.
  - BUSY: hold all mem_cmd_* outputs stable until mem_cmd_valid and mem_cmd_ready are both high.
    - On acceptance of a read, push the granted index into the tag FIFO.
    - On acceptance with a new eligible peripheral, reload the command register in the same cycle and stay in BUSY (back-to-back issue).
    - Otherwise return to IDLE.
- Grant: round-robin.
  - Search starts at last_grant+1 modulo PERIPHERALS.
  - last_grant updates on every load.
  - last_grant resets to PERIPHERALS-1, so peripheral 0 wins first.
- Read return:
  - mem_rd_valid pops the tag FIFO.
  - Next cycle: data_out<=mem_rd_data and data_out_ready<=one-hot(tag), for one cycle.
  - mem_rd_valid while the tag FIFO is empty is ignored; outputs do not change.
- Overflow bits clear only on reset.

## Timing
- Reset values: fifo_full 0, overflow 0, data_out 0, data_out_ready 0, mem_cmd_valid 0, mem_cmd_wr 0, mem_cmd_address 0, mem_cmd_data 0. Reset also clears all FIFOs, the tag FIFO and state IDLE.
- fifo_full[i] is registered and goes high in the cycle after the push that fills the FIFO.
- Latency from push to command: push in cycle n, with an idle arbiter and an empty FIFO, gives mem_cmd_valid=1 at cycle n+2.
- Throughput: one command per cycle when mem_cmd_ready is held high.
- Read data latency: mem_rd_valid in cycle m gives data_out_ready in cycle m+1.
- Reset mid-operation: outstanding reads are forgotten. Late mem_rd_valid after reset is ignored.

## Configuration
- MEM_ARBITER_FIXED_PRIORITY_EN:
  - Defined: fixed priority; the highest eligible index wins and last_grant is unused. This matches the legacy ordering, where the device controller sits at the high index.
  - Undefined: round-robin as above.

## Structure
- Package mem_arbiter_pkg holds:
  - the request word field offsets: wr bit, address, data;
  - the state encoding IDLE/BUSY;
  - a clog2 helper function.
- Sub-module arb_fifo: a generic synchronous FIFO with parameters WIDTH and DEPTH, and full/empty/push/pop ports. It is instantiated PERIPHERALS times for requests and once for tags (WIDTH=clog2(PERIPHERALS)).

## Test plan
- Single write, peripheral 1, address 0x000123, data 0xA5, mem_cmd_ready=1 -> mem_cmd_valid for one cycle at n+2 with wr=1, addr 0x000123, data 0xA5.
- Both peripherals push 4 reads each, ready=1, memory returns immediately -> grant order 0,1,0,1,…; data_out_ready pulses alternate one-hot 01,10 in the same order.
- Five pushes to peripheral 0 with the command stage stalled (ready=0) -> fifo_full[0]=1 after the 4th push; the 5th is dropped and overflow[0]=1; exactly 4 commands are issued after ready rises.
- Stalled memory returns: 4 reads issued with no mem_rd_valid -> the 5th read is withheld while a queued write from peripheral 1 still issues.
- mem_cmd_ready toggling 1,0,0,1 -> command outputs stable across the stall; no duplicate or lost command.
- Reset asserted with 2 reads outstanding, then mem_rd_valid pulses -> no data_out_ready; all outputs at their reset values.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: request word layout, command-stage states and a
// constant clog2 helper shared by the arbiter and its FIFOs.
package mem_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam int REQ_DATA_LSB = 0;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int req_addr_lsb(input int dw);
    return dw;
  endfunction

  function automatic int req_wr_bit(input int aw, input int dw);
    return aw + dw;
  endfunction

  function automatic int req_width(input int aw, input int dw);
    return aw + dw + 1;
  endfunction

endpackage

// File: rtl/arb_fifo.sv
// arb_fifo: synchronous FIFO with registered full/empty flags.
// Pushes while full and pops while empty are ignored.
module arb_fifo
  import mem_arbiter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int CW = clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop && !r_empty;

  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push)
        r_wr_ptr <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;

endmodule

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: N-port memory arbiter with per-port request FIFOs.
// Define MEM_ARBITER_FIXED_PRIORITY_EN for highest-index-wins grant.
module mem_arbiter_rr
  import mem_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH   = 25,
  parameter int DATA_WIDTH      = 8,
  parameter int PERIPHERALS     = 2,
  parameter int REQ_FIFO_DEPTH  = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [PERIPHERALS*ADDRESS_WIDTH-1:0] address,
  input  logic [PERIPHERALS-1:0]               wr,
  input  logic [PERIPHERALS*DATA_WIDTH-1:0]    data_in,
  input  logic [PERIPHERALS-1:0]               data_in_ready,
  output logic [PERIPHERALS-1:0]               fifo_full,
  output logic [PERIPHERALS-1:0]               overflow,
  output logic [DATA_WIDTH-1:0]                data_out,
  output logic [PERIPHERALS-1:0]               data_out_ready,
  output logic                                 mem_cmd_valid,
  input  logic                                 mem_cmd_ready,
  output logic                                 mem_cmd_wr,
  output logic [ADDRESS_WIDTH-1:0]             mem_cmd_address,
  output logic [DATA_WIDTH-1:0]                mem_cmd_data,
  input  logic                                 mem_rd_valid,
  input  logic [DATA_WIDTH-1:0]                mem_rd_data
);

  localparam int AW   = ADDRESS_WIDTH;
  localparam int DW   = DATA_WIDTH;
  localparam int P    = PERIPHERALS;
  localparam int RW   = req_width(AW, DW);
  localparam int WRB  = req_wr_bit(AW, DW);
  localparam int ALSB = req_addr_lsb(DW);
  localparam int IW   = clog2(P);
  localparam int CW   = clog2(MAX_OUTSTANDING + 1);
  localparam logic [P-1:0] ONE_P = 1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [RW-1:0] w_head [P];
  logic [RW-1:0] w_sel;
  logic [P-1:0]  w_empty;
  logic [P-1:0]  w_elig;
  logic [P-1:0]  w_pop;
  logic [P-1:0]  r_ovf;
  logic [P-1:0]  r_rd_rdy;
  logic [IW-1:0] w_gnt;
  logic [IW-1:0] r_cmd_idx;
  logic [IW-1:0] w_tag_head;
  logic          w_any;
  logic          w_accept;
  logic          w_load;
  logic          w_rd_ok;
  logic          w_sel_rd;
  logic          w_tag_full;
  logic          w_tag_empty;
  logic          w_tag_push;
  logic          w_tag_pop;
  logic [CW-1:0] r_rd_cnt;
  logic          r_cmd_wr;
  logic [AW-1:0] r_cmd_addr;
  logic [DW-1:0] r_cmd_data;
  logic [DW-1:0] r_data_out;
`ifndef MEM_ARBITER_FIXED_PRIORITY_EN
  logic [IW-1:0] r_last;
  int            w_idx;
  logic          w_hit;
`endif

  // Reads are counted from load, so a read sitting in the command
  // register already owns a tag slot before it is accepted.
  assign w_rd_ok = (r_rd_cnt < CW'(MAX_OUTSTANDING)) && !w_tag_full;

  for (genvar g = 0; g < P; g++) begin : g_req
    arb_fifo #(
      .WIDTH (RW),
      .DEPTH (REQ_FIFO_DEPTH)
    ) u_req (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (data_in_ready[g]),
      .i_pop   (w_pop[g]),
      .i_data  ({wr[g], address[g*AW +: AW], data_in[g*DW +: DW]}),
      .o_data  (w_head[g]),
      .o_full  (fifo_full[g]),
      .o_empty (w_empty[g])
    );
    assign w_elig[g] = !w_empty[g] && (w_head[g][WRB] || w_rd_ok);
  end

  assign w_any = |w_elig;

`ifdef MEM_ARBITER_FIXED_PRIORITY_EN
  always_comb begin
    w_gnt = '0;
    for (int k = 0; k < P; k++)
      if (w_elig[IW'(k)]) w_gnt = IW'(k);
  end
`else
  always_comb begin
    w_gnt = '0;
    w_idx = 0;
    w_hit = 1'b0;
    for (int k = 1; k <= P; k++) begin
      w_idx = (int'(r_last) + k) % P;
      if (!w_hit && w_elig[IW'(w_idx)]) begin
        w_gnt = IW'(w_idx);
        w_hit = 1'b1;
      end
    end
  end
`endif

  assign w_sel    = w_head[w_gnt];
  assign w_sel_rd = !w_sel[WRB];
  assign w_accept = (r_state == ST_BUSY) && mem_cmd_ready;
  assign w_load   = ((r_state == ST_IDLE) || w_accept) && w_any;
  assign w_pop    = w_load ? (ONE_P << w_gnt) : '0;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_any) w_state_nxt = ST_BUSY;
      ST_BUSY: if (mem_cmd_ready && !w_any) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd_wr   <= 1'b0;
      r_cmd_addr <= '0;
      r_cmd_data <= '0;
      r_cmd_idx  <= '0;
    end else if (w_load) begin
      r_cmd_wr   <= w_sel[WRB];
      r_cmd_addr <= w_sel[ALSB +: AW];
      r_cmd_data <= w_sel[REQ_DATA_LSB +: DW];
      r_cmd_idx  <= w_gnt;
    end
  end

`ifndef MEM_ARBITER_FIXED_PRIORITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_last <= IW'(P - 1);
    else if (w_load) r_last <= w_gnt;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_cnt <= '0;
      r_ovf    <= '0;
    end else begin
      r_rd_cnt <= r_rd_cnt + CW'(w_load && w_sel_rd) - CW'(w_tag_pop);
      r_ovf    <= r_ovf | (data_in_ready & fifo_full);
    end
  end

  assign w_tag_push = w_accept && !r_cmd_wr;
  assign w_tag_pop  = mem_rd_valid && !w_tag_empty;

  arb_fifo #(
    .WIDTH (IW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_tag_push),
    .i_pop   (w_tag_pop),
    .i_data  (r_cmd_idx),
    .o_data  (w_tag_head),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= '0;
      r_rd_rdy   <= '0;
    end else begin
      r_rd_rdy <= w_tag_pop ? (ONE_P << w_tag_head) : '0;
      if (w_tag_pop) r_data_out <= mem_rd_data;
    end
  end

  assign overflow        = r_ovf;
  assign data_out        = r_data_out;
  assign data_out_ready  = r_rd_rdy;
  assign mem_cmd_valid   = (r_state == ST_BUSY);
  assign mem_cmd_wr      = r_cmd_wr;
  assign mem_cmd_address = r_cmd_addr;
  assign mem_cmd_data    = r_cmd_data;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: directed checks of push, grant order, stalls,
// tag-limited reads and reset for mem_arbiter_rr (2 ports).
module tb_mem_arbiter_rr;

  localparam int AW = 25;
  localparam int DW = 8;
  localparam int P  = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [P*AW-1:0] address;
  logic [P-1:0]    wr;
  logic [P*DW-1:0] data_in;
  logic [P-1:0]    data_in_ready;
  logic [P-1:0]    fifo_full;
  logic [P-1:0]    overflow;
  logic [DW-1:0]   data_out;
  logic [P-1:0]    data_out_ready;
  logic            mem_cmd_valid;
  logic            mem_cmd_ready;
  logic            mem_cmd_wr;
  logic [AW-1:0]   mem_cmd_address;
  logic [DW-1:0]   mem_cmd_data;
  logic            mem_rd_valid;
  logic [DW-1:0]   mem_rd_data;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [33:0] got_cmd[$];
  logic [9:0]  got_rd[$];
  logic        auto_ret = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter_rr dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .address         (address),
    .wr              (wr),
    .data_in         (data_in),
    .data_in_ready   (data_in_ready),
    .fifo_full       (fifo_full),
    .overflow        (overflow),
    .data_out        (data_out),
    .data_out_ready  (data_out_ready),
    .mem_cmd_valid   (mem_cmd_valid),
    .mem_cmd_ready   (mem_cmd_ready),
    .mem_cmd_wr      (mem_cmd_wr),
    .mem_cmd_address (mem_cmd_address),
    .mem_cmd_data    (mem_cmd_data),
    .mem_rd_valid    (mem_rd_valid),
    .mem_rd_data     (mem_rd_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] cmdw(input logic w, input logic [24:0] a,
                                       input logic [7:0] d);
    return {w, a, d};
  endfunction

  function automatic logic [33:0] gcmd(input int k);
    return (k < got_cmd.size()) ? got_cmd[k] : '1;
  endfunction

  function automatic logic [9:0] grd(input int k);
    return (k < got_rd.size()) ? got_rd[k] : '1;
  endfunction

  task automatic set_req(input int p, input logic w, input logic [24:0] a,
                         input logic [7:0] d);
    address[p*AW +: AW] = a;
    wr[p]               = w;
    data_in[p*DW +: DW] = d;
    data_in_ready[p]    = 1'b1;
  endtask

  // Finish the current cycle: log the handshake taken at the coming
  // edge, advance, then optionally answer the read one cycle later.
  task automatic cyc();
    logic       pend;
    logic [7:0] rdat;
    pend = auto_ret && mem_cmd_valid && mem_cmd_ready && !mem_cmd_wr;
    rdat = mem_cmd_address[7:0] ^ 8'h5A;
    if (mem_cmd_valid && mem_cmd_ready)
      got_cmd.push_back({mem_cmd_wr, mem_cmd_address, mem_cmd_data});
    @(posedge clk);
    #1;
    mem_rd_valid = pend;
    mem_rd_data  = pend ? rdat : 8'h00;
    if (data_out_ready != '0) got_rd.push_back({data_out_ready, data_out});
  endtask

  initial begin
    logic [24:0] ea;
    reset_n       = 1'b0;
    address       = '0;
    wr            = '0;
    data_in       = '0;
    data_in_ready = '0;
    mem_cmd_ready = 1'b0;
    mem_rd_valid  = 1'b0;
    mem_rd_data   = '0;

    // Reset values
    cyc();
    cyc();
    chk("rst_full", fifo_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_drdy", data_out_ready, 0);
    chk("rst_cvalid", mem_cmd_valid, 0);
    chk("rst_cwr", mem_cmd_wr, 0);
    chk("rst_caddr", mem_cmd_address, 0);
    chk("rst_cdata", mem_cmd_data, 0);
    reset_n = 1'b1;
    cyc();

    // Single write from peripheral 1: valid exactly at n+2
    mem_cmd_ready = 1'b1;
    set_req(1, 1'b1, 25'h000123, 8'hA5);
    cyc();
    data_in_ready = '0;
    chk("t1_valid_n1", mem_cmd_valid, 0);
    cyc();
    chk("t1_valid_n2", mem_cmd_valid, 1);
    chk("t1_wr", mem_cmd_wr, 1);
    chk("t1_addr", mem_cmd_address, 25'h000123);
    chk("t1_data", mem_cmd_data, 8'hA5);
    cyc();
    chk("t1_valid_n3", mem_cmd_valid, 0);

    // Four reads per peripheral, memory answers at once
    got_cmd.delete();
    got_rd.delete();
    auto_ret = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1'b0, 25'h10 + 25'(i), 8'h00);
      set_req(1, 1'b0, 25'h20 + 25'(i), 8'h00);
      cyc();
    end
    data_in_ready = '0;
    repeat (20) cyc();
    chk("t2_ncmd", got_cmd.size(), 8);
    chk("t2_nrd", got_rd.size(), 8);
    for (int k = 0; k < 8; k++) begin
      ea = ((k % 2) == 0) ? 25'h10 + 25'(k / 2) : 25'h20 + 25'(k / 2);
      chk($sformatf("t2_cmd%0d", k), gcmd(k), cmdw(1'b0, ea, 8'h00));
      chk($sformatf("t2_rd%0d", k), grd(k),
          {((k % 2) == 0) ? 2'b01 : 2'b10, ea[7:0] ^ 8'h5A});
    end
    auto_ret = 1'b0;

    // Overflow: park a p1 write in BUSY so p0's FIFO cannot drain
    mem_cmd_ready = 1'b0;
    set_req(1, 1'b1, 25'h66, 8'h99);
    cyc();
    data_in_ready = '0;
    cyc();
    chk("t3_stall_valid", mem_cmd_valid, 1);
    for (int i = 0; i < 5; i++) begin
      set_req(0, 1'b1, 25'h40 + 25'(i), 8'h80 + 8'(i));
      if (i == 3) chk("t3_full_after3", fifo_full[0], 0);
      if (i == 4) chk("t3_full_after4", fifo_full[0], 1);
      chk($sformatf("t3_hold%0d", i), mem_cmd_address, 25'h66);
      cyc();
    end
    data_in_ready = '0;
    chk("t3_ovf", overflow, 2'b01);
    got_cmd.delete();
    mem_cmd_ready = 1'b1;
    repeat (10) cyc();
    chk("t3_ncmd", got_cmd.size(), 5);
    chk("t3_cmd0", gcmd(0), cmdw(1'b1, 25'h66, 8'h99));
    for (int k = 0; k < 4; k++)
      chk($sformatf("t3_cmd%0d", k + 1), gcmd(k + 1),
          cmdw(1'b1, 25'h40 + 25'(k), 8'h80 + 8'(k)));
    chk("t3_full_drained", fifo_full, 0);
    chk("t3_ovf_sticky", overflow, 2'b01);

    // Ready toggling 1,0,0,1 with two queued writes
    got_cmd.delete();
    mem_cmd_ready = 1'b0;
    set_req(0, 1'b1, 25'h55, 8'h11);
    set_req(1, 1'b1, 25'h56, 8'h22);
    cyc();
    data_in_ready = '0;
    cyc();
    chk("t5_first_addr", mem_cmd_address, 25'h56);
    mem_cmd_ready = 1'b1;
    cyc();
    mem_cmd_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("t5_valid%0d", i), mem_cmd_valid, 1);
      chk($sformatf("t5_addr%0d", i), mem_cmd_address, 25'h55);
      chk($sformatf("t5_data%0d", i), mem_cmd_data, 8'h11);
      cyc();
    end
    mem_cmd_ready = 1'b1;
    cyc();
    mem_cmd_ready = 1'b0;
    chk("t5_idle", mem_cmd_valid, 0);
    cyc();
    cyc();
    chk("t5_ncmd", got_cmd.size(), 2);
    chk("t5_cmd0", gcmd(0), cmdw(1'b1, 25'h56, 8'h22));
    chk("t5_cmd1", gcmd(1), cmdw(1'b1, 25'h55, 8'h11));

    // Stalled returns: fifth read waits, p1 write still issues
    got_cmd.delete();
    got_rd.delete();
    mem_cmd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_req(0, 1'b0, 25'h50 + 25'(i), 8'h00);
      cyc();
    end
    data_in_ready = '0;
    set_req(1, 1'b1, 25'h77, 8'h33);
    cyc();
    data_in_ready = '0;
    repeat (8) cyc();
    chk("t4_ncmd", got_cmd.size(), 5);
    for (int k = 0; k < 4; k++)
      chk($sformatf("t4_rd%0d", k), gcmd(k),
          cmdw(1'b0, 25'h50 + 25'(k), 8'h00));
    chk("t4_wr", gcmd(4), cmdw(1'b1, 25'h77, 8'h33));
    chk("t4_withheld", mem_cmd_valid, 0);
    chk("t4_nrd0", got_rd.size(), 0);
    for (int i = 0; i < 4; i++) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = 8'hC0 + 8'(i);
      cyc();
      chk($sformatf("t4_ret%0d", i), {data_out_ready, data_out},
          {2'b01, 8'hC0 + 8'(i)});
    end
    repeat (3) cyc();
    chk("t4_ncmd_after", got_cmd.size(), 6);
    chk("t4_rd4", gcmd(5), cmdw(1'b0, 25'h54, 8'h00));
    mem_rd_valid = 1'b1;
    mem_rd_data  = 8'hD4;
    cyc();
    chk("t4_ret4", {data_out_ready, data_out}, {2'b01, 8'hD4});
    cyc();
    chk("t4_pulse_end", data_out_ready, 0);

    // Two reads in flight, then reset; late returns are ignored
    set_req(0, 1'b0, 25'h61, 8'h00);
    set_req(1, 1'b0, 25'h62, 8'h00);
    cyc();
    data_in_ready = '0;
    repeat (4) cyc();
    chk("t6_ncmd", got_cmd.size(), 8);
    chk("t6_cmd0", gcmd(6), cmdw(1'b0, 25'h62, 8'h00));
    chk("t6_cmd1", gcmd(7), cmdw(1'b0, 25'h61, 8'h00));
    got_rd.delete();
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = 8'hEE;
      cyc();
    end
    cyc();
    chk("t6_nrd", got_rd.size(), 0);
    chk("t6_drdy", data_out_ready, 0);
    chk("t6_dout", data_out, 0);
    chk("t6_ovf", overflow, 0);
    chk("t6_full", fifo_full, 0);
    chk("t6_cvalid", mem_cmd_valid, 0);
    chk("t6_caddr", mem_cmd_address, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
